// File: rtl/demux_chan_monitor.sv
// rtl/demux_chan_monitor.sv - per-channel rising-edge monitor for a 1-to-4 demultiplexer
//
// Samples the four demux outputs y0..y3 every enabled clock, counts rising
// edges per channel in saturating counters, decodes the currently active
// channel and flags illegal multi-hot output patterns.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-high reset (overrides en and clr)
//   en         sample enable; when low all state holds
//   clr        synchronous clear of counters and sticky flags
//   y0..y3     demux output channels
//   y_q        registered sample {y3,y2,y1,y0}
//   cnt0..cnt3 per-channel rising-edge counts, CW bits, saturating
//   sat        sticky per-channel saturation flags
//   active_ch  index of the single high bit of y_q (0 when not one-hot)
//   active_vld high when exactly one bit of y_q is set
//   err_multi  sticky flag, set when more than one input is sampled high

module demux_chan_monitor #(
  parameter int CW = 8  // counter width, intended range 2..16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          y0,
  input  logic          y1,
  input  logic          y2,
  input  logic          y3,
  output logic [3:0]    y_q,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic [3:0]    sat,
  output logic [1:0]    active_ch,
  output logic          active_vld,
  output logic          err_multi
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [3:0]    y_in;
  logic [3:0]    rise;
  logic          multi_hot;
  logic [CW-1:0] cnt_q [4];

  assign y_in = {y3, y2, y1, y0};

  // Edges are judged against the last sampled value, so a pulse that comes
  // and goes while en=0 is never seen.
  assign rise = y_in & ~y_q;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(y_in & (y_in - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      sat       <= '0;
      err_multi <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (clr) begin
      // Capture the live level even when en=0 so a line already high at
      // clear time does not register as a fresh edge afterwards.
      y_q       <= y_in;
      sat       <= '0;
      err_multi <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (en) begin
      y_q <= y_in;
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            sat[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end
      end
      if (multi_hot) begin
        err_multi <= 1'b1;
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

  // Only a strictly one-hot sample names an active channel.
  always_comb begin
    active_vld = 1'b0;
    active_ch  = 2'd0;
    case (y_q)
      4'b0001: begin active_vld = 1'b1; active_ch = 2'd0; end
      4'b0010: begin active_vld = 1'b1; active_ch = 2'd1; end
      4'b0100: begin active_vld = 1'b1; active_ch = 2'd2; end
      4'b1000: begin active_vld = 1'b1; active_ch = 2'd3; end
      default: begin active_vld = 1'b0; active_ch = 2'd0; end
    endcase
  end

endmodule

// File: tb/tb_demux_chan_monitor.sv
// tb/tb_demux_chan_monitor.sv - self-checking bench for demux_chan_monitor (CW=8 and CW=4)

module tb_demux_chan_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] y   = 4'd0;

  logic [3:0] a_yq, b_yq, a_sat, b_sat;
  logic [7:0] a_c0, a_c1, a_c2, a_c3;
  logic [3:0] b_c0, b_c1, b_c2, b_c3;
  logic [1:0] a_ch, b_ch;
  logic       a_vld, b_vld, a_err, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_chan_monitor #(.CW(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
    .y_q(a_yq), .cnt0(a_c0), .cnt1(a_c1), .cnt2(a_c2), .cnt3(a_c3),
    .sat(a_sat), .active_ch(a_ch), .active_vld(a_vld), .err_multi(a_err)
  );

  demux_chan_monitor #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
    .y_q(b_yq), .cnt0(b_c0), .cnt1(b_c1), .cnt2(b_c2), .cnt3(b_c3),
    .sat(b_sat), .active_ch(b_ch), .active_vld(b_vld), .err_multi(b_err)
  );

  logic [7:0] a_cnt [4];
  logic [3:0] b_cnt [4];
  assign a_cnt[0] = a_c0; assign a_cnt[1] = a_c1; assign a_cnt[2] = a_c2; assign a_cnt[3] = a_c3;
  assign b_cnt[0] = b_c0; assign b_cnt[1] = b_c1; assign b_cnt[2] = b_c2; assign b_cnt[3] = b_c3;

  // Reference model: last sample, plain integer counts clamped at 2^CW-1.
  int         m_prev [4];
  int         m_cnt8 [4];
  int         m_cnt4 [4];
  logic [3:0] m_sat8, m_sat4;
  logic       m_err;

  task automatic model_step(input logic r, input logic e, input logic c, input logic [3:0] yv);
    if (r || c) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt8[i] = 0;
        m_cnt4[i] = 0;
        m_prev[i] = r ? 0 : int'(yv[i]);
      end
      m_sat8 = 4'd0;
      m_sat4 = 4'd0;
      m_err  = 1'b0;
    end else if (e) begin
      int ones = 0;
      for (int i = 0; i < 4; i++) begin
        if (yv[i]) ones++;
        if (yv[i] && m_prev[i] == 0) begin
          if (m_cnt8[i] == 255) m_sat8[i] = 1'b1; else m_cnt8[i]++;
          if (m_cnt4[i] == 15)  m_sat4[i] = 1'b1; else m_cnt4[i]++;
        end
        m_prev[i] = int'(yv[i]);
      end
      if (ones > 1) m_err = 1'b1;
    end
  endtask

  function automatic logic [3:0] m_yq();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_prev[i] != 0);
    return v;
  endfunction

  function automatic logic m_vld();
    int ones = 0;
    for (int i = 0; i < 4; i++) if (m_prev[i] != 0) ones++;
    return ones == 1;
  endfunction

  function automatic logic [1:0] m_ch();
    logic [1:0] ch = 2'd0;
    if (m_vld()) for (int i = 0; i < 4; i++) if (m_prev[i] != 0) ch = 2'(i);
    return ch;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic c, input logic [3:0] yv);
    rst = r; en = e; clr = c; y = yv;
    @(posedge clk);
    model_step(r, e, c, yv);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 4'd0);
    cycle(1, 1, 1, 4'hF);
    cycle(0, 1, 0, 4'd0);
    total++; if (a_yq !== 4'd0) begin bad++; $display("FAIL reset_yq got=%h want=0", a_yq); end
    for (int i = 0; i < 4; i++) begin
      total++; if (a_cnt[i] !== 8'd0) begin bad++; $display("FAIL reset_cnt%0d got=%0d want=0", i, a_cnt[i]); end
    end
    total++; if (a_sat !== 4'd0 || b_sat !== 4'd0) begin bad++; $display("FAIL reset_sat got=%h/%h want=0", a_sat, b_sat); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", a_err); end
    total++; if (a_vld !== 1'b0 || a_ch !== 2'd0) begin bad++; $display("FAIL reset_active got=%b/%0d want=0/0", a_vld, a_ch); end
  endtask

  task automatic test_sequence();
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, 4'(1 << k));
      total++; if (a_vld !== 1'b1 || a_ch !== 2'(k)) begin bad++; $display("FAIL seq_active%0d got=%b/%0d want=1/%0d", k, a_vld, a_ch, k); end
      total++; if (a_cnt[k] !== 8'd1) begin bad++; $display("FAIL seq_cnt%0d got=%0d want=1", k, a_cnt[k]); end
    end
    cycle(0, 1, 0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      total++; if (a_cnt[i] !== 8'd1 || b_cnt[i] !== 4'd1) begin bad++; $display("FAIL seq_final_cnt%0d got=%0d/%0d want=1", i, a_cnt[i], b_cnt[i]); end
    end
    total++; if (a_err !== 1'b0 || a_vld !== 1'b0) begin bad++; $display("FAIL seq_err_vld got=%b/%b want=0/0", a_err, a_vld); end
  endtask

  task automatic test_saturation();
    cycle(0, 1, 1, 4'd0);
    for (int p = 1; p <= 17; p++) begin
      cycle(0, 1, 0, 4'b0100);
      total++; if (b_c2 !== 4'(p > 15 ? 15 : p)) begin bad++; $display("FAIL sat_cnt2_p%0d got=%0d want=%0d", p, b_c2, (p > 15 ? 15 : p)); end
      total++; if (b_sat !== (p >= 16 ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL sat_flag_p%0d got=%b want=%b", p, b_sat, (p >= 16 ? 4'b0100 : 4'b0000)); end
      total++; if (a_c2 !== 8'(p) || a_sat !== 4'd0) begin bad++; $display("FAIL sat_cw8_p%0d got=%0d/%b want=%0d/0000", p, a_c2, a_sat, p); end
      cycle(0, 1, 0, 4'd0);
    end
    total++; if (b_c0 !== 4'd0 || b_c1 !== 4'd0 || b_c3 !== 4'd0) begin bad++; $display("FAIL sat_others got=%0d/%0d/%0d want=0", b_c0, b_c1, b_c3); end
  endtask

  task automatic test_clear();
    cycle(0, 1, 1, 4'd0);
    cycle(0, 1, 0, 4'b0001);
    total++; if (a_c0 !== 8'd1) begin bad++; $display("FAIL clr_before got=%0d want=1", a_c0); end
    cycle(0, 1, 1, 4'b0001);
    total++; if (a_c0 !== 8'd0 || a_yq !== 4'b0001) begin bad++; $display("FAIL clr_during got=%0d/%b want=0/0001", a_c0, a_yq); end
    cycle(0, 1, 0, 4'b0001);
    total++; if (a_c0 !== 8'd0) begin bad++; $display("FAIL clr_release got=%0d want=0", a_c0); end
    cycle(0, 1, 0, 4'd0);
    cycle(0, 1, 0, 4'b0001);
    total++; if (a_c0 !== 8'd1) begin bad++; $display("FAIL clr_rerise got=%0d want=1", a_c0); end
    cycle(0, 1, 0, 4'd0);
    cycle(0, 0, 1, 4'b1010);
    total++; if (a_c1 !== 8'd0 || a_err !== 1'b0 || a_yq !== 4'b1010) begin bad++; $display("FAIL clr_wins got=%0d/%b/%b want=0/0/1010", a_c1, a_err, a_yq); end
  endtask

  task automatic test_multi();
    cycle(0, 1, 1, 4'd0);
    cycle(0, 1, 0, 4'b1010);
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL multi_err got=%b want=1", a_err); end
    total++; if (a_c1 !== 8'd1 || a_c3 !== 8'd1) begin bad++; $display("FAIL multi_cnt got=%0d/%0d want=1/1", a_c1, a_c3); end
    total++; if (a_vld !== 1'b0 || a_ch !== 2'd0) begin bad++; $display("FAIL multi_active got=%b/%0d want=0/0", a_vld, a_ch); end
    cycle(0, 1, 0, 4'b0001);
    total++; if (a_err !== 1'b1 || a_vld !== 1'b1 || a_ch !== 2'd0) begin bad++; $display("FAIL multi_sticky got=%b/%b/%0d want=1/1/0", a_err, a_vld, a_ch); end
    cycle(0, 1, 1, 4'd0);
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL multi_clr got=%b want=0", a_err); end
  endtask

  task automatic test_hold();
    cycle(0, 1, 1, 4'd0);
    cycle(0, 0, 0, 4'b0001);
    total++; if (a_yq !== 4'd0 || a_c0 !== 8'd0) begin bad++; $display("FAIL hold_high got=%b/%0d want=0000/0", a_yq, a_c0); end
    cycle(0, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd0);
    total++; if (a_c0 !== 8'd0) begin bad++; $display("FAIL hold_cnt got=%0d want=0", a_c0); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 4'd0);
    for (int p = 0; p < 5; p++) begin
      cycle(0, 1, 0, 4'b0010);
      cycle(0, 1, 0, 4'd0);
    end
    total++; if (a_c1 !== 8'd5) begin bad++; $display("FAIL rstmid_pre got=%0d want=5", a_c1); end
    cycle(1, 1, 0, 4'b0010);
    total++; if (a_c1 !== 8'd0 || a_yq !== 4'd0) begin bad++; $display("FAIL rstmid_post got=%0d/%b want=0/0000", a_c1, a_yq); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      logic [3:0] yv;
      yv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) yv = 4'd0;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) != 0), ($urandom_range(0, 39) == 0), yv);
      total++; if (a_yq !== m_yq() || b_yq !== m_yq()) begin bad++; $display("FAIL rnd_yq n=%0d got=%b/%b want=%b", n, a_yq, b_yq, m_yq()); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (a_cnt[i] !== 8'(m_cnt8[i]) || b_cnt[i] !== 4'(m_cnt4[i])) begin
          bad++; $display("FAIL rnd_cnt%0d n=%0d got=%0d/%0d want=%0d/%0d", i, n, a_cnt[i], b_cnt[i], m_cnt8[i], m_cnt4[i]);
        end
      end
      total++; if (a_sat !== m_sat8 || b_sat !== m_sat4) begin bad++; $display("FAIL rnd_sat n=%0d got=%b/%b want=%b/%b", n, a_sat, b_sat, m_sat8, m_sat4); end
      total++; if (a_err !== m_err || b_err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b/%b want=%b", n, a_err, b_err, m_err); end
      total++; if (a_vld !== m_vld() || a_ch !== m_ch() || b_vld !== m_vld() || b_ch !== m_ch()) begin
        bad++; $display("FAIL rnd_active n=%0d got=%b/%0d want=%b/%0d", n, a_vld, a_ch, m_vld(), m_ch());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 0; m_cnt8[i] = 0; m_cnt4[i] = 0;
    end
    m_sat8 = 4'd0; m_sat4 = 4'd0; m_err = 1'b0;
    test_reset();
    test_sequence();
    test_saturation();
    test_clear();
    test_multi();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
